pipelined_hybrid_adder: RTL and testbench
=========================================

# pipelined_hybrid_adder

Parametrised, two-stage pipelined signed adder/subtractor built on the team's hybrid block-carry-lookahead / carry-select architecture. Width and block size are generic, subtraction is selected per transaction, and operands/results move over a valid/ready handshake with full backpressure. Sits in the datapath wherever a registered, throughput-one add/sub is needed, e.g. accumulator and filter tap sums.

## Interface
- WIDTH, 25, operand/result width in bits; must be an integer multiple of BLOCK, minimum 2
- BLOCK, 5, carry-select block size in bits; minimum 1
- clk  input  1  sole clock, rising edge
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk
- in_valid  input  1  operand beat valid
- in_ready  output  1  block accepts operand beat this cycle
- a  input  WIDTH  signed operand A
- b  input  WIDTH  signed operand B
- sub  input  1  0: A+B, 1: A-B
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  signed result
- overflow  output  1  signed overflow of this result
- carry_out  output  1  unsigned carry out of MSB (borrow-complement when sub=1)
- ovf_sticky  output  1  set by any delivered overflow, held until clr
- clr  input  1  clears ovf_sticky

## Operation
- Effective operand: bx = sub ? ~b : b; carry-in c0 = sub.
- Bit g = a & bx, p = a ^ bx; block G/P per BLOCK bits; block carries C[k+1] = G[k] | P[k]&C[k], C[0]=c0.
- Per block, two ripple sums (cin 0 and 1); block carry C[k] selects.
- overflow = (a[MSB] == bx[MSB]) & (sum[MSB] != a[MSB]) on unsaturated sum; carry_out = C[WIDTH/BLOCK].
- Stage 1: accept beat, compute g/p, block G/P, block carries; register p, g, carries, a[MSB], bx[MSB].
- Stage 2: carry select, overflow, saturation (if enabled); register outputs.
- Transfer at a port occurs when valid & ready both high on a rising edge.
- Stage advance: s2_free = ~out_valid | out_ready; s1_free = ~s1_valid | s2_free; in_ready = s1_free (combinational, no dependency on in_valid).
- Output payload held stable while out_valid=1 and out_ready=0.
- ovf_sticky sets on a result transfer with overflow=1; clr clears it; same-cycle set and clr -> set wins (sticky=1).

## Timing
- Latency: 2 cycles from input transfer to out_valid with result.
- Throughput: one beat per cycle with out_ready held high.
- Backpressure: with out_ready low, pipeline holds at most 2 beats; in_ready drops the cycle after both stages fill.
- Reset (rst_n=0 at edge): all valids 0, sum 0, overflow 0, carry_out 0, ovf_sticky 0; in-flight beats discarded, no partial result emitted; in_ready=1 the first cycle after release.
- Reset asserted mid-transaction overrides any simultaneous transfer.

## Configuration
- ADDER_SAT_EN defined: on overflow, sum clamps to 2^(WIDTH-1)-1 (a[MSB]=0) or -2^(WIDTH-1) (a[MSB]=1); overflow and carry_out still reported from the raw addition.
- ADDER_SAT_EN undefined: sum is the wrapped two's-complement result.

## Test plan
- WIDTH=25, BLOCK=5: a=1000, b=234, sub=0 -> after 2 cycles sum=1234, overflow=0, carry_out=0.
- a=5, b=7, sub=1 -> sum=-2, overflow=0, carry_out=0; a=7, b=5, sub=1 -> sum=2, carry_out=1.
- a=16777215, b=1, sub=0 -> overflow=1, ovf_sticky=1; sum=-16777216 without ADDER_SAT_EN, 16777215 with it; then clr=1 -> ovf_sticky=0.
- Random stream of 1000 beats, random in_valid/out_ready -> every result matches a±b mod 2^25 in order, no drops/duplicates, payload stable under stall.
- Fill pipeline with out_ready=0, then rst_n=0 one cycle -> out_valid=0, all outputs 0, ovf_sticky=0, no stale beat after release.
- WIDTH=32, BLOCK=4 and WIDTH=8, BLOCK=8: exhaustive/random add and sub against reference model, including -2^(WIDTH-1) - 1 overflow.

Source files
------------

// File: rtl/pipelined_hybrid_adder.sv
// Two-stage signed add/sub: block carry-lookahead carries in stage 1, carry-select block sums in stage 2.
// Latency 2 cycles from input transfer to registered result; throughput one beat per cycle.
// Valid/ready backpressure, holds up to two beats, in_ready = stage 1 free; ADDER_SAT_EN enables saturation.
module pipelined_hybrid_adder #(
  parameter int WIDTH = 25,
  parameter int BLOCK = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             overflow,
  output logic             carry_out,
  output logic             ovf_sticky,
  input  logic             clr
);

  localparam int NB = WIDTH / BLOCK;

  // Stage 1 combinational signals
  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [NB-1:0]    blk_g;
  logic [NB-1:0]    blk_p;
  logic [NB:0]      blk_c;

  // Stage 1 registers
  logic             s1_valid;
  logic [WIDTH-1:0] s1_g;
  logic [WIDTH-1:0] s1_p;
  logic [NB:0]      s1_c;
  logic             s1_amsb;
  logic             s1_bmsb;

  // Stage 2 combinational signals
  logic [WIDTH-1:0] sum0;
  logic [WIDTH-1:0] sum1;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] res;
  logic             rc0;
  logic             rc1;
  logic             ovf;

  // Handshake
  logic s2_free;
  logic s1_free;

  // Stage advance: a stage may load when it is empty or its contents move on this cycle
  always_comb begin
    s2_free  = ~out_valid | out_ready;
    s1_free  = ~s1_valid | s2_free;
    in_ready = s1_free;
  end

  // Bit generate/propagate, block generate/propagate and the lookahead block carry chain
  always_comb begin
    bx    = sub ? ~b : b;
    g     = a & bx;
    p     = a ^ bx;
    blk_g = '0;
    blk_p = '1;
    blk_c = '0;
    for (int k = 0; k < NB; k++) begin
      for (int i = 0; i < BLOCK; i++) begin
        blk_g[k] = g[k*BLOCK+i] | (p[k*BLOCK+i] & blk_g[k]);
        blk_p[k] = blk_p[k] & p[k*BLOCK+i];
      end
    end
    blk_c[0] = sub;
    for (int k = 0; k < NB; k++) begin
      blk_c[k+1] = blk_g[k] | (blk_p[k] & blk_c[k]);
    end
  end

  // Stage 1 register: capture g/p, block carries and sign bits of the effective operands
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_g     <= '0;
      s1_p     <= '0;
      s1_c     <= '0;
      s1_amsb  <= 1'b0;
      s1_bmsb  <= 1'b0;
    end else if (s1_free) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_g    <= g;
        s1_p    <= p;
        s1_c    <= blk_c;
        s1_amsb <= a[WIDTH-1];
        s1_bmsb <= bx[WIDTH-1];
      end
    end
  end

  // Per block, ripple both carry-in hypotheses and let the block carry pick one
  always_comb begin
    sum0 = '0;
    sum1 = '0;
    raw  = '0;
    rc0  = 1'b0;
    rc1  = 1'b1;
    for (int k = 0; k < NB; k++) begin
      rc0 = 1'b0;
      rc1 = 1'b1;
      for (int i = 0; i < BLOCK; i++) begin
        sum0[k*BLOCK+i] = s1_p[k*BLOCK+i] ^ rc0;
        sum1[k*BLOCK+i] = s1_p[k*BLOCK+i] ^ rc1;
        rc0 = s1_g[k*BLOCK+i] | (s1_p[k*BLOCK+i] & rc0);
        rc1 = s1_g[k*BLOCK+i] | (s1_p[k*BLOCK+i] & rc1);
      end
      for (int i = 0; i < BLOCK; i++) begin
        raw[k*BLOCK+i] = s1_c[k] ? sum1[k*BLOCK+i] : sum0[k*BLOCK+i];
      end
    end
    // Overflow is judged on the raw result even when saturating
    ovf = (s1_amsb == s1_bmsb) & (raw[WIDTH-1] != s1_amsb);
    res = raw;
`ifdef ADDER_SAT_EN
    if (ovf) begin
      res = s1_amsb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // Stage 2 register: result payload only changes when the stage is free
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      overflow  <= 1'b0;
      carry_out <= 1'b0;
    end else if (s2_free) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sum       <= res;
        overflow  <= ovf;
        carry_out <= s1_c[NB];
      end
    end
  end

  // Sticky overflow: a delivered overflow beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
    end else if (out_valid & out_ready & overflow) begin
      ovf_sticky <= 1'b1;
    end else if (clr) begin
      ovf_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipelined_hybrid_adder.sv
// Directed table plus multi-cycle sequences for the add/sub pipeline.
// Checks latency, handshake, sticky overflow, reset flush and streaming order.
// Secondary instances cover WIDTH=8/BLOCK=8 and WIDTH=32/BLOCK=4.
module tb_pipelined_hybrid_adder;

  localparam int W = 25;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, in_valid, in_ready, sub, out_valid, out_ready;
  logic         overflow, carry_out, ovf_sticky, clr;
  logic [W-1:0] a, b, sum;

  logic       v8_iv, v8_ir, v8_sub, v8_ov_vld, v8_or, v8_ovf, v8_co, v8_st;
  logic [7:0] v8_a, v8_b, v8_sum;
  logic        v32_iv, v32_ir, v32_sub, v32_ov_vld, v32_or, v32_ovf, v32_co, v32_st;
  logic [31:0] v32_a, v32_b, v32_sum;

  pipelined_hybrid_adder #(.WIDTH(W), .BLOCK(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .overflow(overflow), .carry_out(carry_out),
    .ovf_sticky(ovf_sticky), .clr(clr)
  );

  pipelined_hybrid_adder #(.WIDTH(8), .BLOCK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8_iv), .in_ready(v8_ir),
    .a(v8_a), .b(v8_b), .sub(v8_sub), .out_valid(v8_ov_vld), .out_ready(v8_or),
    .sum(v8_sum), .overflow(v8_ovf), .carry_out(v8_co),
    .ovf_sticky(v8_st), .clr(1'b0)
  );

  pipelined_hybrid_adder #(.WIDTH(32), .BLOCK(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32_iv), .in_ready(v32_ir),
    .a(v32_a), .b(v32_b), .sub(v32_sub), .out_valid(v32_ov_vld), .out_ready(v32_or),
    .sum(v32_sum), .overflow(v32_ovf), .carry_out(v32_co),
    .ovf_sticky(v32_st), .clr(1'b0)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] s;
    logic         ov;
    logic         co;
  } vec_t;

  vec_t tbl[11];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  bit   exp_sticky;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Arithmetic reference: plain integer add of the effective operands
  function automatic void ref_model(input int w, input logic [63:0] x, input logic [63:0] y,
                                    input logic s, output logic [63:0] r,
                                    output logic ov, output logic co);
    logic [64:0] mask, bxm, full;
    mask = (65'd1 << w) - 65'd1;
    bxm  = (s ? ~{1'b0, y} : {1'b0, y}) & mask;
    full = ({1'b0, x} & mask) + bxm + {64'd0, s};
    co   = full[w];
    r    = full[63:0] & mask[63:0];
    ov   = (x[w-1] == bxm[w-1]) && (r[w-1] != x[w-1]);
`ifdef ADDER_SAT_EN
    if (ov) r = x[w-1] ? (64'd1 << (w-1)) : (mask[63:0] >> 1);
`endif
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    bit found;
    @(negedge clk);
    a = v.a; b = v.b; sub = v.sub; in_valid = 1'b1;
    #1 check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    found = 1'b0;
    while (!found && lat < 8) begin
      @(negedge clk);
      lat++;
      found = out_valid;
    end
    check({tag, "_latency"}, 64'(lat), 64'd2);
    check({tag, "_sum"}, 64'(sum), 64'(v.s));
    check({tag, "_ovf_cout"}, 64'({overflow, carry_out}), 64'({v.ov, v.co}));
    if (v.ov) exp_sticky = 1'b1;
    @(negedge clk);
    check({tag, "_sticky"}, 64'(ovf_sticky), 64'(exp_sticky));
    check({tag, "_drained"}, 64'(out_valid), 64'd0);
  endtask

  logic [W+1:0]  q25[$];
  logic [9:0]    q8[$];
  logic [33:0]   q32[$];
  logic [W+1:0]  held;
  logic [W+1:0]  e25;
  logic [9:0]    e8;
  logic [33:0]   e32;
  logic [63:0]   r;
  logic          rov, rco;
  logic [7:0]    ca8[3]  = '{8'h80, 8'h7f, 8'h00};
  logic [7:0]    cb8[3]  = '{8'h01, 8'h01, 8'h80};
  logic          cs8[3]  = '{1'b1, 1'b0, 1'b1};
  logic [31:0]   ca32[3] = '{32'h8000_0000, 32'h7fff_ffff, 32'hffff_ffff};
  logic [31:0]   cb32[3] = '{32'h1, 32'h1, 32'h1};
  logic          cs32[3] = '{1'b1, 1'b0, 1'b0};

  initial begin
    int  sent, recv, cyc, stale, s8, r8, s32, r32;
    bit  hold_pend, found;

    // Hand-computed vectors for WIDTH=25
    tbl[0]  = '{25'd1000,     25'd234,      1'b0, 25'd1234,     1'b0, 1'b0};
    tbl[1]  = '{25'd5,        25'd7,        1'b1, 25'd33554430, 1'b0, 1'b0};
    tbl[2]  = '{25'd7,        25'd5,        1'b1, 25'd2,        1'b0, 1'b1};
`ifdef ADDER_SAT_EN
    tbl[3]  = '{25'd16777215, 25'd1,        1'b0, 25'd16777215, 1'b1, 1'b0};
    tbl[6]  = '{25'd16777216, 25'd1,        1'b1, 25'd16777216, 1'b1, 1'b1};
`else
    tbl[3]  = '{25'd16777215, 25'd1,        1'b0, 25'd16777216, 1'b1, 1'b0};
    tbl[6]  = '{25'd16777216, 25'd1,        1'b1, 25'd16777215, 1'b1, 1'b1};
`endif
    tbl[4]  = '{25'd0,        25'd0,        1'b0, 25'd0,        1'b0, 1'b0};
    tbl[5]  = '{25'd33554431, 25'd33554431, 1'b0, 25'd33554430, 1'b0, 1'b1};
    tbl[7]  = '{25'd0,        25'd0,        1'b1, 25'd0,        1'b0, 1'b1};
    tbl[8]  = '{25'd33554431, 25'd1,        1'b0, 25'd0,        1'b0, 1'b1};
    tbl[9]  = '{25'd12345,    25'd12345,    1'b1, 25'd0,        1'b0, 1'b1};
    tbl[10] = '{25'd11184810, 25'd22369621, 1'b0, 25'd33554431, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr = 1'b0;
    a = '0; b = '0; sub = 1'b0; exp_sticky = 1'b0;
    v8_iv = 1'b0; v8_or = 1'b1; v8_a = '0; v8_b = '0; v8_sub = 1'b0;
    v32_iv = 1'b0; v32_or = 1'b1; v32_a = '0; v32_b = '0; v32_sub = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_outputs", 64'({out_valid, overflow, carry_out, ovf_sticky, sum}), 64'd0);
    rst_n = 1'b1;
    #1 check("reset_in_ready", 64'(in_ready), 64'd1);

    // Directed table
    for (int i = 0; i < 11; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Backpressure fill, then reset flush
    @(negedge clk);
    out_ready = 1'b0;
    a = tbl[6].a; b = tbl[6].b; sub = tbl[6].sub; in_valid = 1'b1;
    @(negedge clk);
    a = tbl[0].a; b = tbl[0].b; sub = tbl[0].sub;
    #1 check("fill_in_ready_one", 64'(in_ready), 64'd1);
    @(negedge clk);
    a = tbl[1].a; b = tbl[1].b; sub = tbl[1].sub;
    #1 check("fill_full", 64'({in_ready, out_valid}), 64'b01);
    check("fill_head", 64'({overflow, carry_out, sum}), 64'({tbl[6].ov, tbl[6].co, tbl[6].s}));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 check($sformatf("stall_hold%0d", i), 64'({in_ready, out_valid, overflow, carry_out, sum}),
               64'({1'b0, 1'b1, tbl[6].ov, tbl[6].co, tbl[6].s}));
    end
    @(negedge clk);
    rst_n = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    exp_sticky = 1'b0;
    #1 check("flush_outputs", 64'({out_valid, overflow, carry_out, ovf_sticky, sum}), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    stale = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("flush_no_stale", 64'(stale), 64'd0);

    // Overflow delivery and clr in the same cycle: set wins
    @(negedge clk);
    a = tbl[3].a; b = tbl[3].b; sub = tbl[3].sub; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      found = out_valid;
    end
    check("setclr_found", 64'(found), 64'd1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("setclr_set_wins", 64'(ovf_sticky), 64'd1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_clears", 64'(ovf_sticky), 64'd0);

    // Random stream with random valid/ready
    sent = 0; recv = 0; cyc = 0; hold_pend = 1'b0; held = '0;
    while (recv < 1000 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (hold_pend)
        check("stream_stall_stable", 64'({out_valid, overflow, carry_out, sum}), 64'({1'b1, held}));
      in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      a         = W'($urandom);
      b         = W'($urandom);
      sub       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (in_valid && in_ready) begin
        ref_model(W, 64'(a), 64'(b), sub, r, rov, rco);
        q25.push_back({rov, rco, r[W-1:0]});
        sent++;
      end
      if (out_valid && out_ready) begin
        if (q25.size() == 0) begin
          check("stream_unexpected_beat", 64'd1, 64'd0);
        end else begin
          e25 = q25.pop_front();
          check("stream_beat", 64'({overflow, carry_out, sum}), 64'(e25));
        end
        recv++;
      end
      hold_pend = out_valid && !out_ready;
      held      = {overflow, carry_out, sum};
    end
    check("stream_recv_count", 64'(recv), 64'd1000);
    check("stream_queue_empty", 64'(q25.size()), 64'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("stream_no_duplicate", 64'(stale), 64'd0);

    // WIDTH=8/BLOCK=8 and WIDTH=32/BLOCK=4: corners then random, both streaming
    s8 = 0; r8 = 0; s32 = 0; r32 = 0; cyc = 0;
    while ((r8 < 2000 || r32 < 2000) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      v8_iv  = (s8 < 2000);
      v32_iv = (s32 < 2000);
      if (s8 < 3) begin
        v8_a = ca8[s8]; v8_b = cb8[s8]; v8_sub = cs8[s8];
      end else begin
        v8_a = 8'($urandom); v8_b = 8'($urandom); v8_sub = 1'($urandom_range(0, 1));
      end
      if (s32 < 3) begin
        v32_a = ca32[s32]; v32_b = cb32[s32]; v32_sub = cs32[s32];
      end else begin
        v32_a = $urandom; v32_b = $urandom; v32_sub = 1'($urandom_range(0, 1));
      end
      #1;
      if (v8_iv && v8_ir) begin
        ref_model(8, 64'(v8_a), 64'(v8_b), v8_sub, r, rov, rco);
        q8.push_back({rov, rco, r[7:0]});
        s8++;
      end
      if (v32_iv && v32_ir) begin
        ref_model(32, 64'(v32_a), 64'(v32_b), v32_sub, r, rov, rco);
        q32.push_back({rov, rco, r[31:0]});
        s32++;
      end
      if (v8_ov_vld) begin
        e8 = (q8.size() != 0) ? q8.pop_front() : 10'h3ff;
        check("w8_beat", 64'({v8_ovf, v8_co, v8_sum}), 64'(e8));
        r8++;
      end
      if (v32_ov_vld) begin
        e32 = (q32.size() != 0) ? q32.pop_front() : 34'h3_ffff_ffff;
        check("w32_beat", 64'({v32_ovf, v32_co, v32_sum}), 64'(e32));
        r32++;
      end
    end
    check("w8_recv_count", 64'(r8), 64'd2000);
    check("w32_recv_count", 64'(r32), 64'd2000);
    check("w8_sticky_seen", 64'(v8_st), 64'd1);
    v8_iv = 1'b0; v32_iv = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
